// File: rtl/cart_mem_pkg.sv
// cart_mem_pkg: shared types and address mapping for the cart/BIOS SDRAM arbiter.
package cart_mem_pkg;
  typedef enum logic [1:0] {IDLE, WR_CMD, RD_CMD, BUSY} state_t;
  localparam logic [3:0] BIOS_PAGE = 4'hF;
  function automatic logic [15:0] map_dl_addr(input logic index0, input logic [15:0] addr);
    return index0 ? addr : {BIOS_PAGE, addr[11:0]};
  endfunction
endpackage

// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter: sequences ROM download writes and core cart reads onto one SDRAM port.
// Defining CART_PREFETCH_EN adds a speculative read of the next cart address.
module cart_mem_arbiter
  import cart_mem_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int MEM_CYC = 6
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        cart_rd,
  input  logic [15:0] cart_addr,
  output logic [7:0]  cart_do,
  output logic        cart_valid,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [7:0]  mem_dout,
  output logic        wr_overrun
);
  state_t state;
  logic [15:0] hold_addr, req_addr, cur_addr, rd_next, ld_addr;
  logic [7:0] hold_data, cnt, ld_data;
  logic wr_pend, cur_valid, dl_q;
  logic wr_in, dl_fall, rd_trig, sample_ok, done, idle_free, rd_go, ld_cur, unused_ok;
  assign wr_in = ioctl_download & ioctl_wr;
  assign dl_fall = dl_q & ~ioctl_download;
  assign rd_trig = ~ioctl_download & cart_rd & (~cur_valid | (cur_addr != cart_addr));
  assign idle_free = (state == IDLE) & ~wr_pend;
  // cnt counts cycles since the strobe; mem_dout is captured on the edge closing strobe+MEM_LAT-1
  assign sample_ok = (state == BUSY) & (cnt == 8'(MEM_LAT - 1)) & ~ioctl_download;
  assign done = (state == BUSY) & (cnt == 8'(MEM_CYC - 2));
  assign unused_ok = ^{ioctl_index[7:1], ioctl_addr[24:16]};
`ifdef CART_PREFETCH_EN
  logic [15:0] pf_addr;
  logic [7:0] pf_data;
  logic pf_valid, pf_want, spec, pf_hit, pf_go, pf_take;
  assign pf_hit = pf_valid & (pf_addr == cart_addr);
  assign pf_take = idle_free & rd_trig & pf_hit;
  assign pf_go = idle_free & ~rd_trig & pf_want & ~ioctl_download;
  assign rd_go = (idle_free & rd_trig & ~pf_hit) | pf_go;
  assign rd_next = pf_go ? cur_addr + 16'd1 : cart_addr;
  assign ld_cur = (sample_ok & ~spec) | pf_take;
  assign ld_addr = pf_take ? pf_addr : req_addr;
  assign ld_data = pf_take ? pf_data : mem_dout;
  always_ff @(posedge clk_sys)
    if (!reset_n) begin
      pf_addr <= '0;
      pf_data <= '0;
      pf_valid <= 1'b0;
      pf_want <= 1'b0;
      spec <= 1'b0;
    end else begin
      if (rd_go) spec <= pf_go;
      if (sample_ok & spec) begin
        pf_addr <= req_addr;
        pf_data <= mem_dout;
        pf_valid <= 1'b1;
      end
      if (wr_in | dl_fall) pf_valid <= 1'b0;
      pf_want <= (sample_ok & ~spec) | (pf_want & ~(rd_go | pf_take | wr_in | dl_fall));
    end
`else
  assign rd_go = idle_free & rd_trig;
  assign rd_next = cart_addr;
  assign ld_cur = sample_ok;
  assign ld_addr = req_addr;
  assign ld_data = mem_dout;
`endif
  always_ff @(posedge clk_sys)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      wr_pend <= 1'b0;
      wr_overrun <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
      req_addr <= '0;
      cur_addr <= '0;
      cur_valid <= 1'b0;
      dl_q <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
      mem_we <= 1'b0;
      mem_rd <= 1'b0;
      cart_do <= '0;
      cart_valid <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      cart_valid <= cur_valid & (cur_addr == cart_addr);
      mem_we <= 1'b0;
      mem_rd <= 1'b0;
      // a held byte that is not being issued this cycle is never overwritten
      if (wr_in && wr_pend && state != WR_CMD) wr_overrun <= 1'b1;
      else if (wr_in) begin
        hold_addr <= map_dl_addr(ioctl_index[0], ioctl_addr[15:0]);
        hold_data <= ioctl_dout;
        wr_pend <= 1'b1;
      end else if (state == WR_CMD) wr_pend <= 1'b0;
      if (ld_cur) begin
        cart_do <= ld_data;
        cur_addr <= ld_addr;
        cur_valid <= 1'b1;
      end
      if (dl_fall) cur_valid <= 1'b0;
      case (state)
        IDLE:
          if (wr_pend) begin
            state <= WR_CMD;
            mem_we <= 1'b1;
            mem_addr <= hold_addr;
            mem_din <= hold_data;
          end else if (rd_go) begin
            state <= RD_CMD;
            mem_rd <= 1'b1;
            mem_addr <= rd_next;
            req_addr <= rd_next;
          end
        WR_CMD, RD_CMD: begin
          state <= BUSY;
          cnt <= 8'd1;
        end
        default: begin
          cnt <= cnt + 8'd1;
          if (done) state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_cart_mem_arbiter.sv
// tb_cart_mem_arbiter: directed checks of write mapping, overrun, read latency, prefetch and reset.
module tb_cart_mem_arbiter;
  localparam int MEM_LAT = 4;
  localparam int MEM_CYC = 6;
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;
  logic reset_n, ioctl_download, ioctl_wr, cart_rd, cart_valid, mem_we, mem_rd, wr_overrun;
  logic [7:0] ioctl_index, ioctl_dout, cart_do, mem_din, mem_dout;
  logic [24:0] ioctl_addr;
  logic [15:0] cart_addr, mem_addr;
  logic [15:0] raddr = '0, last_rd_addr = '0;
  logic [7:0] age = '0;
  int vecs = 0, errs = 0, we_cnt = 0, rd_cnt = 0;

  cart_mem_arbiter #(.MEM_LAT(MEM_LAT), .MEM_CYC(MEM_CYC)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .cart_rd(cart_rd), .cart_addr(cart_addr),
    .cart_do(cart_do), .cart_valid(cart_valid), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd), .mem_dout(mem_dout),
    .wr_overrun(wr_overrun)
  );

  // SDRAM model: read data is only present in the single cycle the arbiter samples it
  function automatic logic [7:0] sdram_byte(input logic [15:0] a);
    return (a == 16'h0040) ? 8'hA7 : a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction
  assign mem_dout = (age == 8'(MEM_LAT - 1)) ? sdram_byte(raddr) : 8'hEE;
  always @(posedge clk_sys) begin
    if (mem_we) we_cnt <= we_cnt + 1;
    if (mem_rd) begin
      rd_cnt <= rd_cnt + 1;
      raddr <= mem_addr;
      last_rd_addr <= mem_addr;
      age <= 8'd1;
    end else if (age != 0) age <= age + 8'd1;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index = '0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    cart_rd = 1'b0;
    cart_addr = '0;
    cyc(2);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_rd", mem_rd, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_din", mem_din, 0);
    chk("rst cart_do", cart_do, 0);
    chk("rst cart_valid", cart_valid, 0);
    chk("rst wr_overrun", wr_overrun, 0);
    reset_n = 1'b1;
    ioctl_download = 1'b1;
    cyc(1);
    // BIOS write: strobe at N, mem_we at N+2
    ioctl_index = 8'h00;
    ioctl_addr = 25'h0123;
    ioctl_dout = 8'h5A;
    ioctl_wr = 1'b1;
    cyc(1);
    ioctl_wr = 1'b0;
    chk("bios we early", mem_we, 0);
    cyc(1);
    chk("bios we", mem_we, 1);
    chk("bios addr", mem_addr, 16'hF123);
    chk("bios din", mem_din, 8'h5A);
    cyc(1);
    chk("bios we one cycle", mem_we, 0);
    // cart write arriving in BUSY waits for the command spacing
    ioctl_index = 8'h01;
    ioctl_addr = 25'h1_2345;
    ioctl_dout = 8'hC3;
    ioctl_wr = 1'b1;
    cyc(1);
    ioctl_wr = 1'b0;
    cyc(3);
    chk("cart we spacing", mem_we, 0);
    cyc(1);
    chk("cart we", mem_we, 1);
    chk("cart addr", mem_addr, 16'h2345);
    chk("cart din", mem_din, 8'hC3);
    // overrun: two back-to-back strobes during BUSY
    cyc(1);
    ioctl_addr = 25'h0777;
    ioctl_dout = 8'h11;
    ioctl_wr = 1'b1;
    cyc(1);
    ioctl_addr = 25'h0888;
    ioctl_dout = 8'h22;
    chk("ovr before", wr_overrun, 0);
    cyc(1);
    ioctl_wr = 1'b0;
    chk("ovr set", wr_overrun, 1);
    cyc(3);
    chk("ovr held we", mem_we, 1);
    chk("ovr held addr", mem_addr, 16'h0777);
    chk("ovr held din", mem_din, 8'h11);
    cyc(12);
    chk("ovr we count", we_cnt, 3);
    chk("ovr sticky", wr_overrun, 1);
    ioctl_download = 1'b0;
    cyc(3);
    // read latency
    cart_rd = 1'b1;
    cart_addr = 16'h0040;
    chk("rd idle", mem_rd, 0);
    cyc(1);
    chk("rd strobe", mem_rd, 1);
    chk("rd addr", mem_addr, 16'h0040);
    cyc(3);
    chk("rd do early", cart_do, 8'h00);
    cyc(1);
    chk("rd do", cart_do, 8'hA7);
    chk("rd valid early", cart_valid, 0);
    cyc(1);
    chk("rd valid", cart_valid, 1);
    cyc(12);
`ifdef CART_PREFETCH_EN
    chk("rd hold count", rd_cnt, 2);
    chk("pf spec addr", last_rd_addr, 16'h0041);
`else
    chk("rd hold count", rd_cnt, 1);
`endif
    chk("rd hold valid", cart_valid, 1);
    cart_addr = 16'h0041;
    cyc(1);
    chk("addr change drop", cart_valid, 0);
`ifdef CART_PREFETCH_EN
    chk("pf hit do", cart_do, 8'h7D);
    cyc(1);
    chk("pf hit valid", cart_valid, 1);
    chk("pf hit no rd", rd_cnt, 2);
    cyc(10);
    cart_addr = 16'h00FF;
    cyc(1);
    chk("pf ff rd", mem_addr, 16'h00FF);
    cyc(4);
    chk("pf ff do", cart_do, 8'hC3);
    cyc(12);
    chk("pf 100 spec", last_rd_addr, 16'h0100);
    chk("pf 100 count", rd_cnt, 4);
    cart_addr = 16'h0100;
    cyc(1);
    chk("pf 100 do", cart_do, 8'h3D);
    cyc(1);
    chk("pf 100 valid", cart_valid, 1);
    chk("pf 100 no rd", rd_cnt, 4);
    cart_addr = 16'hFFFF;
    cyc(1);
    chk("pf ffff rd", mem_addr, 16'hFFFF);
    cyc(16);
    chk("pf wrap addr", last_rd_addr, 16'h0000);
    chk("pf wrap count", rd_cnt, 6);
`else
    cyc(4);
    chk("rd2 do", cart_do, 8'h7D);
    cyc(1);
    chk("rd2 valid", cart_valid, 1);
    chk("rd2 count", rd_cnt, 2);
`endif
    // reset two cycles after a read strobe
    cyc(4);
    cart_addr = 16'h0200;
    cyc(1);
    chk("mid rd strobe", mem_rd, 1);
    cyc(2);
    chk("mid ovr before", wr_overrun, 1);
    reset_n = 1'b0;
    cart_rd = 1'b0;
    cyc(1);
    chk("mid mem_rd", mem_rd, 0);
    chk("mid mem_we", mem_we, 0);
    chk("mid mem_addr", mem_addr, 0);
    chk("mid cart_do", cart_do, 0);
    chk("mid cart_valid", cart_valid, 0);
    chk("mid wr_overrun", wr_overrun, 0);
    reset_n = 1'b1;
    cyc(6);
    chk("mid discard do", cart_do, 0);
    chk("mid discard valid", cart_valid, 0);
`ifdef CART_PREFETCH_EN
    chk("mid rd count", rd_cnt, 7);
`else
    chk("mid rd count", rd_cnt, 3);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
